// File: rtl/prog_loader_pkg.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader_pkg
// Brief   : Shared FSM state encoding and word geometry for prog_loader.
//           PROG_LOADER_CHECKSUM_EN adds the CHECK state.
// Revision: 1.0
// ============================================================================
package prog_loader_pkg;

    localparam int BYTES_PER_WORD = 4;
    localparam int BYTE_CNT_W     = $clog2(BYTES_PER_WORD);
    localparam int SHIFT_W        = 8 * (BYTES_PER_WORD - 1);
    localparam int WORD_W         = 8 * BYTES_PER_WORD;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RECV  = 3'd1,
        ST_WRITE = 3'd2,
`ifdef PROG_LOADER_CHECKSUM_EN
        ST_CHECK = 3'd3,
`endif
        ST_DONE  = 3'd4
    } state_t;

    // Word index to byte address, matching PC-style indexing.
    function automatic logic [31:0] word_byte_addr(input logic [31:0] word_idx);
        return word_idx << 2;
    endfunction

endpackage
`default_nettype wire

// File: rtl/prog_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader_byte_assembler
// Brief   : Big-endian byte-to-word shift register with byte counter.
// Revision: 1.0
// ============================================================================
module prog_loader_byte_assembler
    import prog_loader_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              clear,
    input  logic              shift_en,
    input  logic [7:0]        byte_in,
    output logic [WORD_W-1:0] word_next,
    output logic              word_ready
);
    localparam logic [BYTE_CNT_W-1:0] C_LAST_BYTE = BYTE_CNT_W'(BYTES_PER_WORD - 1);
    localparam logic [BYTE_CNT_W-1:0] C_CNT_ONE   = BYTE_CNT_W'(1);

    logic [SHIFT_W-1:0]    shift_q, shift_d;
    logic [BYTE_CNT_W-1:0] cnt_q, cnt_d;

    // word_next is the full word including the byte being accepted this cycle.
    assign word_ready = shift_en && (cnt_q == C_LAST_BYTE);
    assign word_next  = {shift_q, byte_in};

    always_comb begin
        shift_d = shift_q;
        cnt_d   = cnt_q;
        if (clear) begin
            shift_d = '0;
            cnt_d   = '0;
        end else if (shift_en) begin
            shift_d = {shift_q[SHIFT_W-9:0], byte_in};
            cnt_d   = word_ready ? '0 : cnt_q + C_CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            shift_q <= '0;
            cnt_q   <= '0;
        end else begin
            shift_q <= shift_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : prog_loader
// Brief   : Streams bytes into instruction memory and holds the CPU in reset
//           until a load completes. PROG_LOADER_CHECKSUM_EN adds err + CHECK.
// Revision: 1.0
// ============================================================================
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                start,
    input  logic [ADDR_WIDTH:0] num_words,
    input  logic [7:0]          rx_data,
    input  logic                rx_valid,
    output logic                rx_ready,
    output logic                imem_we,
    output logic [31:0]         imem_addr,
    output logic [31:0]         imem_wdata,
    output logic                cpu_reset,
    output logic                busy,
    output logic                done
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    output logic                err
`endif
);
    localparam int               CNT_W       = ADDR_WIDTH + 1;
    localparam logic [CNT_W-1:0] C_MAX_WORDS = {1'b1, {ADDR_WIDTH{1'b0}}};
    localparam logic [CNT_W-1:0] C_CNT_ONE   = CNT_W'(1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   num_q, num_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;
    logic               rx_ready_q, rx_ready_d;
    logic               imem_we_q, imem_we_d;
    logic [31:0]        imem_addr_q, imem_addr_d;
    logic [31:0]        imem_wdata_q, imem_wdata_d;
    logic               cpu_reset_q, cpu_reset_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
    logic [7:0]         sum_q, sum_d;
    logic [7:0]         w_sum_next;
    logic               err_q, err_d;
`endif

    logic               w_xfer;
    logic               w_start_ok;
    logic               w_word_ready;
    logic [WORD_W-1:0]  w_word;
    logic [CNT_W-1:0]   w_num_clip;
    logic [CNT_W-1:0]   w_cnt_inc;

    assign w_xfer     = rx_valid && rx_ready_q;
    assign w_start_ok = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign w_num_clip = (num_words > C_MAX_WORDS) ? C_MAX_WORDS : num_words;
    assign w_cnt_inc  = word_cnt_q + C_CNT_ONE;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign w_sum_next = sum_q + rx_data;
`endif

    prog_loader_byte_assembler u_asm (
        .clock      (clock),
        .reset      (reset),
        .clear      (w_start_ok),
        .shift_en   (w_xfer && (state_q == ST_RECV)),
        .byte_in    (rx_data),
        .word_next  (w_word),
        .word_ready (w_word_ready)
    );

    always_comb begin
        state_d    = state_q;
        num_d      = num_q;
        word_cnt_d = word_cnt_q;
`ifdef PROG_LOADER_CHECKSUM_EN
        sum_d      = sum_q;
        err_d      = err_q;
`endif
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (w_start_ok) begin
                    num_d      = w_num_clip;
                    word_cnt_d = '0;
                    state_d    = (w_num_clip == '0) ? ST_DONE : ST_RECV;
`ifdef PROG_LOADER_CHECKSUM_EN
                    sum_d      = 8'h00;
                    err_d      = 1'b0;
`endif
                end
            end
            ST_RECV: begin
`ifdef PROG_LOADER_CHECKSUM_EN
                if (w_xfer) sum_d = w_sum_next;
`endif
                if (w_word_ready) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                word_cnt_d = w_cnt_inc;
                if (w_cnt_inc == num_q) begin
`ifdef PROG_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_RECV;
                end
            end
`ifdef PROG_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (w_xfer) begin
                    if (w_sum_next == 8'h00) begin
                        state_d = ST_DONE;
                    end else begin
                        state_d = ST_IDLE;
                        err_d   = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Outputs are registered from the next state so they line up with it.
        rx_ready_d   = (state_d == ST_RECV)
`ifdef PROG_LOADER_CHECKSUM_EN
                       || (state_d == ST_CHECK)
`endif
                       ;
        imem_we_d    = (state_d == ST_WRITE);
        imem_addr_d  = imem_we_d ? word_byte_addr(32'(word_cnt_d[ADDR_WIDTH-1:0])) : imem_addr_q;
        imem_wdata_d = imem_we_d ? w_word : imem_wdata_q;
        busy_d       = (state_d != ST_IDLE) && (state_d != ST_DONE);
        done_d       = (state_d == ST_DONE);
        cpu_reset_d  = (state_d != ST_DONE);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q      <= ST_IDLE;
            num_q        <= '0;
            word_cnt_q   <= '0;
            rx_ready_q   <= 1'b0;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_reset_q  <= 1'b1;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q        <= 8'h00;
            err_q        <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            num_q        <= num_d;
            word_cnt_q   <= word_cnt_d;
            rx_ready_q   <= rx_ready_d;
            imem_we_q    <= imem_we_d;
            imem_addr_q  <= imem_addr_d;
            imem_wdata_q <= imem_wdata_d;
            cpu_reset_q  <= cpu_reset_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_q        <= sum_d;
            err_q        <= err_d;
`endif
        end
    end

    assign rx_ready   = rx_ready_q;
    assign imem_we    = imem_we_q;
    assign imem_addr  = imem_addr_q;
    assign imem_wdata = imem_wdata_q;
    assign cpu_reset  = cpu_reset_q;
    assign busy       = busy_q;
    assign done       = done_q;
`ifdef PROG_LOADER_CHECKSUM_EN
    assign err        = err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_prog_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_prog_loader
// Brief   : Randomized self-checking bench for prog_loader (ADDR_WIDTH 8 and 2).
//           Honours PROG_LOADER_CHECKSUM_EN.
// Revision: 1.0
// ============================================================================
module tb_prog_loader;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start_a, start_b;
    logic [8:0]  num_a;
    logic [2:0]  num_b;
    logic [7:0]  rx_data;
    logic        rx_valid;

    logic        a_rx_ready, a_we, a_cpu_reset, a_busy, a_done, a_err;
    logic [31:0] a_addr, a_wdata;
    logic        b_rx_ready, b_we, b_cpu_reset, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_wdata;

    prog_loader #(.ADDR_WIDTH(8)) u_dut_a (
        .clock(clk), .reset(rst_n), .start(start_a), .num_words(num_a),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(a_rx_ready),
        .imem_we(a_we), .imem_addr(a_addr), .imem_wdata(a_wdata),
        .cpu_reset(a_cpu_reset), .busy(a_busy), .done(a_done)
`ifdef PROG_LOADER_CHECKSUM_EN
        , .err(a_err)
`endif
    );

    prog_loader #(.ADDR_WIDTH(2)) u_dut_b (
        .clock(clk), .reset(rst_n), .start(start_b), .num_words(num_b),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(b_rx_ready),
        .imem_we(b_we), .imem_addr(b_addr), .imem_wdata(b_wdata),
        .cpu_reset(b_cpu_reset), .busy(b_busy), .done(b_done)
`ifdef PROG_LOADER_CHECKSUM_EN
        , .err(b_err)
`endif
    );

`ifndef PROG_LOADER_CHECKSUM_EN
    assign a_err = 1'b0;
    assign b_err = 1'b0;
`endif

    int          n_checks = 0;
    int          n_fail   = 0;
    logic [7:0]  prog_q[$];
    logic [63:0] got_a[$];
    logic [63:0] got_b[$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic int clip_words(input int n, input int aw);
        int cap = 1 << aw;
        return (n > cap) ? cap : n;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference for DUT A: every fourth program byte accepted must be
    // followed one cycle later by exactly one write.
    int m_bytes = 0;
    int m_words = 0;
    bit m_exp_we = 1'b0;
    always @(negedge clk) begin
        bit idle;
        if (!rst_n) begin
            m_bytes  = 0;
            m_words  = 0;
            m_exp_we = 1'b0;
        end else begin
            if (m_exp_we || a_we) check_eq("a_we_latency", 64'(a_we), 64'(m_exp_we));
            if (a_we) begin
                check_eq("a_ready_in_write", 64'(a_rx_ready), 64'd0);
                got_a.push_back({a_addr, a_wdata});
            end
            idle     = !m_exp_we && (m_bytes >= 4 * m_words);
            m_exp_we = 1'b0;
            if (start_a && idle) begin
                m_bytes = 0;
                m_words = clip_words(int'(num_a), 8);
            end else if (rx_valid && a_rx_ready && (m_bytes < 4 * m_words)) begin
                m_bytes++;
                if (m_bytes % 4 == 0) m_exp_we = 1'b1;
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_we) begin
            check_eq("b_ready_in_write", 64'(b_rx_ready), 64'd0);
            got_b.push_back({b_addr, b_wdata});
        end
    end

    task automatic send_byte(input bit sel_b, input logic [7:0] b);
        int gap = $urandom_range(0, 2);
        bit rdy;
        bit sent = 1'b0;
        for (int i = 0; i < gap; i++) begin
            rx_valid = 1'b0;
            rx_data  = 8'($urandom);
            tick();
        end
        rx_data  = b;
        rx_valid = 1'b1;
        for (int n = 0; n < 40 && !sent; n++) begin
            @(negedge clk);
            rdy = sel_b ? b_rx_ready : a_rx_ready;
            tick();
            sent = rdy;
        end
        check_eq("rx_handshake", 64'(sent), 64'd1);
        rx_valid = 1'b0;
    endtask

    // trail < 0 means send the correct checksum byte.
    task automatic run_session(input bit sel_b, input int num, input bit poke, input int trail);
        int          aw    = sel_b ? 2 : 8;
        int          words = clip_words(num, aw);
        logic [63:0] exp_q[$];
        logic [63:0] got[$];
        logic [7:0]  sum   = 8'h00;
        logic [7:0]  tb_byte;
        logic [7:0]  tot;
        bit          pass  = 1'b1;
        bit          ok    = 1'b0;
        for (int i = 0; i < words; i++)
            exp_q.push_back({32'(4 * i), prog_q[4*i], prog_q[4*i+1], prog_q[4*i+2], prog_q[4*i+3]});
        if (sel_b) got_b.delete(); else got_a.delete();
        if (sel_b) begin num_b = 3'(num); start_b = 1'b1; end
        else       begin num_a = 9'(num); start_a = 1'b1; end
        tick();
        start_a = 1'b0;
        start_b = 1'b0;
        for (int i = 0; i < 4 * words; i++) begin
            send_byte(sel_b, prog_q[i]);
            sum = sum + prog_q[i];
            if (poke && i == 0) begin
                start_a = 1'b1;
                num_a   = 9'd0;
                tick();
                start_a = 1'b0;
            end
        end
`ifdef PROG_LOADER_CHECKSUM_EN
        if (words > 0) begin
            tb_byte = (trail < 0) ? 8'(8'h00 - sum) : 8'(trail);
            tot     = sum + tb_byte;
            pass    = (tot == 8'h00);
            send_byte(sel_b, tb_byte);
        end
`else
        tb_byte = 8'(trail);
        tot     = sum + tb_byte;
`endif
        for (int n = 0; n < 20 && !ok; n++) begin
            @(negedge clk);
            ok = sel_b ? (b_done || b_err) : (a_done || a_err);
        end
        check_eq("session_end", 64'(ok), 64'd1);
        check_eq("done",      64'(sel_b ? b_done : a_done), 64'(pass));
        check_eq("cpu_reset", 64'(sel_b ? b_cpu_reset : a_cpu_reset), 64'(!pass));
        check_eq("busy",      64'(sel_b ? b_busy : a_busy), 64'd0);
`ifdef PROG_LOADER_CHECKSUM_EN
        check_eq("err",       64'(sel_b ? b_err : a_err), 64'(!pass));
`endif
        if (sel_b) got = got_b; else got = got_a;
        check_eq("write_count", 64'(got.size()), 64'(exp_q.size()));
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got.size()) check_eq($sformatf("write[%0d]", i), got[i], exp_q[i]);
        tick();
    endtask

    initial begin
        rst_n    = 1'b0;
        start_a  = 1'b0;
        start_b  = 1'b0;
        num_a    = '0;
        num_b    = '0;
        rx_data  = '0;
        rx_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_rx_ready",  64'(a_rx_ready), 64'd0);
        check_eq("rst_we",        64'(a_we), 64'd0);
        check_eq("rst_addr",      64'(a_addr), 64'd0);
        check_eq("rst_wdata",     64'(a_wdata), 64'd0);
        check_eq("rst_busy",      64'(a_busy), 64'd0);
        check_eq("rst_done",      64'(a_done), 64'd0);
        check_eq("rst_cpu_reset", 64'(a_cpu_reset), 64'd1);
        check_eq("rst_err",       64'(a_err), 64'd0);
        tick();
        rst_n = 1'b1;
        tick();

        // Two-word directed program
        prog_q = '{8'h20, 8'h08, 8'h00, 8'h05, 8'h8C, 8'h09, 8'h00, 8'h04};
        run_session(1'b0, 2, 1'b0, -1);

        // Zero-length load goes straight to DONE without writing
        got_a.delete();
        num_a   = 9'd0;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        @(negedge clk);
        check_eq("zero_done",   64'(a_done), 64'd1);
        check_eq("zero_writes", 64'(got_a.size()), 64'd0);
        tick();

        // Randomized sessions; one pulses start mid-load
        for (int s = 0; s < 6; s++) begin
            prog_q.delete();
            for (int i = 0; i < 16; i++) prog_q.push_back(8'($urandom));
            run_session(1'b0, int'($urandom_range(1, 4)), s == 2, -1);
        end

        // Reset in the middle of a word abandons it
        got_a.delete();
        num_a   = 9'd1;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        send_byte(1'b0, 8'hAA);
        send_byte(1'b0, 8'hBB);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("abort_cpu_reset", 64'(a_cpu_reset), 64'd1);
        check_eq("abort_busy",      64'(a_busy), 64'd0);
        check_eq("abort_rx_ready",  64'(a_rx_ready), 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check_eq("abort_writes", 64'(got_a.size()), 64'd0);
        prog_q = '{8'h11, 8'h22, 8'h33, 8'h44};
        run_session(1'b0, 1, 1'b0, -1);

        // Length larger than the small memory is clipped
        prog_q.delete();
        for (int i = 0; i < 16; i++) prog_q.push_back(8'($urandom));
        run_session(1'b1, 7, 1'b0, -1);
        check_eq("clip_last_addr", 64'(b_addr), 64'hC);
        prog_q.delete();
        for (int i = 0; i < 16; i++) prog_q.push_back(8'($urandom));
        run_session(1'b1, 3, 1'b0, -1);

`ifdef PROG_LOADER_CHECKSUM_EN
        prog_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_session(1'b0, 1, 1'b0, 8'hFC);
        run_session(1'b0, 1, 1'b0, 8'hFD);
        run_session(1'b0, 1, 1'b0, -1);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
